// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational instruction memory,
// queues {instr, pc} pairs in a small prefetch FIFO and applies redirects from execute.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err
);

  localparam int unsigned       PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];

  logic push;
  logic pop;
  logic fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty && out_ready;
  // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
  assign push          = (state_q == RUN) && fetch_en && !redirect_valid &&
                         ((count_q < DEPTH_C) || pop);

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;

    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      // Redirect wins over everything: flush the queue and drop any same-cycle pop/push.
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      fpc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
        fpc_d  = fpc_q + STEP_C;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wptr_q] <= imem_data;
      pc_q[wptr_q]    <= fpc_q;
    end
  end

  assign imem_addr    = fpc_q;
  assign out_valid    = fifo_nonempty;
  assign out_instr    = fifo_nonempty ? instr_q[rptr_q] : '0;
  assign out_pc       = fifo_nonempty ? pc_q[rptr_q]    : '0;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a small combinational program ROM.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image for the low 64 bytes; anything else returns a tagged address pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr[31:6] != '0) return {16'hC0DE, addr[15:0]};
    case (addr[5:2])
      4'd0:    return 32'h0000_0000;
      4'd1:    return 32'h0010_1083;
      4'd2:    return 32'h0020_8113;
      4'd3:    return 32'h0020_81B3;
      4'd4:    return 32'h0031_0233;
      4'd5:    return 32'h0042_02B3;
      4'd6:    return 32'h0052_8333;
      4'd7:    return 32'h0063_03B3;
      4'd8:    return 32'h0073_8433;
      4'd9:    return 32'h0084_04B3;
      4'd10:   return 32'h0094_8533;
      4'd11:   return 32'h00A5_05B3;
      4'd12:   return 32'h00B5_8633;
      4'd13:   return 32'h00C6_06B3;
      4'd14:   return 32'hFE00_0EE3;
      default: return 32'h0000_006F;
    endcase
  endfunction

  always_comb imem_data = rom_word(imem_addr);

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, " pc"},    out_pc,             pc);
    checkOutput({tag, " instr"}, out_instr,          rom_word(pc));
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values.
    applyStimulus();
    checkOutput("rst valid",    {31'd0, out_valid},    32'd0);
    checkOutput("rst instr",    out_instr,             32'd0);
    checkOutput("rst pc",       out_pc,                32'd0);
    checkOutput("rst misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("rst imem",     imem_addr,             32'd0);

    // Streaming: RUN at edge 1, first push at edge 2, then one per cycle.
    reset = 1'b0;
    applyStimulus();
    checkOutput("e1 valid", {31'd0, out_valid}, 32'd0);
    checkOutput("e1 imem",  imem_addr,          32'd0);
    applyStimulus();
    checkOutput("e2 instr", out_instr, 32'h0000_0000);
    checkHead("e2", 32'd0);
    checkOutput("e2 imem", imem_addr, 32'd4);
    applyStimulus();
    checkOutput("e3 instr", out_instr, 32'h0010_1083);
    checkHead("e3", 32'd4);
    applyStimulus();
    checkHead("e4", 32'd8);
    applyStimulus();
    checkHead("e5", 32'd12);

    // Backpressure from reset: FIFO fills with pc 0/4 and fetch stalls at 8.
    reset     = 1'b1;
    out_ready = 1'b0;
    #1;
    checkOutput("rst2 valid", {31'd0, out_valid}, 32'd0);
    applyStimulus();
    reset = 1'b0;
    repeat (4) applyStimulus();
    checkHead("full", 32'd0);
    checkOutput("full imem", imem_addr, 32'd8);
    applyStimulus();
    checkHead("full hold", 32'd0);
    checkOutput("full hold imem", imem_addr, 32'd8);

    // Pop and push on the same edge while full.
    out_ready = 1'b1;
    applyStimulus();
    checkHead("pp", 32'd4);
    checkOutput("pp imem", imem_addr, 32'd12);
    applyStimulus();
    checkHead("pp2", 32'd8);
    for (int n = 0; n < 7; n++) begin
      applyStimulus();
      checkOutput("stream pc", out_pc, 32'd12 + 32'(n) * 32'd4);
    end
    checkOutput("pre-redir imem", imem_addr, 32'd44);

    // Redirect to 44 while the FIFO holds 36/40.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd44;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("redir bubble", {31'd0, out_valid}, 32'd0);
    checkOutput("redir imem",   imem_addr,          32'd44);
    applyStimulus();
    checkHead("redir t0", 32'd44);
    applyStimulus();
    checkHead("redir t1", 32'd48);

    // Misaligned redirect: flag sets, fetch uses the aligned target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_003A;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("mis bubble", {31'd0, out_valid},    32'd0);
    checkOutput("mis flag",   {31'd0, misalign_err}, 32'd1);
    applyStimulus();
    checkHead("mis head", 32'h0000_0038);

    // Wrap of the fetch PC past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("wrap bubble", {31'd0, out_valid},    32'd0);
    checkOutput("mis sticky",  {31'd0, misalign_err}, 32'd1);
    applyStimulus();
    checkHead("wrap top", 32'hFFFF_FFFC);
    checkOutput("wrap imem", imem_addr, 32'd0);
    applyStimulus();
    checkHead("wrap zero", 32'd0);

    // Asynchronous reset mid-stream.
    reset = 1'b1;
    #1;
    checkOutput("arst valid",    {31'd0, out_valid},    32'd0);
    checkOutput("arst misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("arst imem",     imem_addr,             32'd0);
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("restart e1", {31'd0, out_valid}, 32'd0);
    applyStimulus();
    checkHead("restart e2", 32'd0);

    // fetch_en low: FIFO drains, PC holds, resume from the same PC.
    fetch_en = 1'b0;
    applyStimulus();
    checkOutput("drain valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain instr", out_instr,          32'd0);
    checkOutput("drain imem",  imem_addr,          32'd4);
    applyStimulus();
    checkOutput("hold imem", imem_addr, 32'd4);
    fetch_en = 1'b1;
    applyStimulus();
    checkOutput("resume idle", {31'd0, out_valid}, 32'd0);
    applyStimulus();
    checkHead("resume", 32'd4);
    checkOutput("resume instr", out_instr, 32'h0010_1083);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequences the combinational instruction memory.
- Owns the fetch PC, presents the byte address to the memory, and captures the returned word with its PC into a small prefetch FIFO.
- Hands instruction/PC pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects (BEQ, JAL, JALR) that flush the FIFO and restart fetch at the target.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_en  in  1  1 = fetch allowed; 0 = hold PC, keep FIFO contents.
- imem_addr  out  ADDR_W  byte address to instruction memory (= fetch PC).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  ADDR_W  byte address of out_instr.
- redirect_valid  in  1  single-cycle redirect request from execute.
- redirect_pc  in  ADDR_W  redirect target byte address.
- misalign_err  out  1  sticky; set when redirect_pc[1:0] != 0.

Behaviour:
- Reset (async):
  - fpc = RESET_PC, FIFO count = 0, read/write pointers = 0, state = IDLE.
  - out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
- State machine:
  - IDLE: no fetch. IDLE -> RUN when fetch_en = 1.
  - RUN: fetching. RUN -> IDLE when fetch_en = 0.
  - Redirects are processed in both states.
- imem_addr = fpc, combinational from the register, always driven.
- Push condition: state = RUN, fetch_en = 1, redirect_valid = 0, and (count < DEPTH or pop this cycle).
- On push:
  - FIFO[wptr] <= {imem_data, fpc}.
  - fpc <= fpc + PC_STEP, modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
- Pop: out_valid && out_ready advances rptr.
- Push and pop in the same cycle leaves count unchanged; this is legal when full.
- out_valid = (count != 0). out_instr/out_pc come from FIFO[rptr]; they are 0 when empty.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1.
  - From reset release with fetch_en = 1: RUN entered at edge 1, first push at edge 2, out_valid = 1 after edge 2.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Full (count = DEPTH) with out_ready = 0: no push, fpc holds, imem_addr stable.
- Redirect (highest priority):
  - On the edge with redirect_valid = 1: count, rptr and wptr go to 0, and any same-cycle pop and push are discarded.
  - fpc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - out_valid = 0 in the following cycle; the first target instruction is valid one cycle after that (redirect penalty = 2 cycles).
  - If redirect_pc[1:0] != 0, misalign_err <= 1 and stays set until reset. Fetch continues at the aligned address.
- fetch_en = 0 mid-operation: the FIFO drains normally, no new pushes, fpc holds. Resuming continues at the same fpc.
- Reset asserted mid-stream: everything returns to reset values asynchronously, and the in-flight FIFO contents are lost.
- imem_data is sampled only on push edges. Its value is not checked: all-zero words are queued like any other.

Test Plan:
- Release reset, fetch_en = 1, out_ready = 1, memory loaded with the processor program:
  - out_valid rises after edge 2.
  - out_pc sequence 0, 4, 8, 12, one per cycle.
  - At pc 4: out_instr = 0x0010_1083. At pc 0: out_instr = 0x0000_0000.
- out_ready = 0 from start:
  - count saturates at 2 with FIFO holding pc 0, 4.
  - imem_addr held at 8.
  - Raising out_ready resumes 0, 4, 8 with no gap or duplicate.
- Full FIFO plus out_ready = 1 in the same cycle: pop of pc 0 and push of pc 8 on one edge, count stays 2.
- redirect_valid pulse with redirect_pc = 44 while FIFO holds pc 36/40:
  - Both entries flushed, out_valid = 0 for one cycle.
  - Next out_pc = 44, then 48.
- redirect_pc = 0x3A: misalign_err = 1 (sticky), next out_pc = 0x38.
- Force fpc to 0xFFFF_FFFC via redirect: next outputs pc 0xFFFF_FFFC, then 0x0000_0000. Then assert reset mid-stream: out_valid = 0 immediately, restart from pc 0.
